// File: rtl/alu_issue_unit_pkg.sv
// Shared constants and types for the ALU issue unit: opcodes, ALU control
// codes, flag bit positions and FSM state encoding.
package alu_issue_unit_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_unit_op_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into an ALU control code,
// an operand-B select and an illegal-operation indication.
module alu_op_decode
  import alu_issue_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       use_imm,
  output logic       illegal
);

  logic is_r;
  logic is_i;

  assign is_r = (opcode == OP_R);
  assign is_i = (opcode == OP_I);

  always_comb begin
    alu_control = ALU_ADD;
    use_imm     = is_i;
    illegal     = 1'b0;
    if (!(is_r || is_i)) begin
      illegal = 1'b1;
    end else begin
      unique case (funct3)
        // funct7b5 only selects subtract for register-register ops
        3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: illegal     = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential front end for the combinational ALU: accepts one decoded op,
// registers operands, captures result/flags a cycle later, returns a response.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid is high and not taken.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retire_count
);

  state_e           state_q, state_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_control_q, alu_control_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  logic [2:0]       dec_control;
  logic             dec_use_imm;
  logic             dec_illegal;
  logic [3:0]       alu_flags;

  alu_op_decode u_decode (
    .opcode      (in_opcode),
    .funct3      (in_funct3),
    .funct7b5    (in_funct7b5),
    .alu_control (dec_control),
    .use_imm     (dec_use_imm),
    .illegal     (dec_illegal)
  );

  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_negative;
    alu_flags[FLAG_Z] = alu_zero;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_V] = alu_overflow;
  end

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_control_d  = alu_control_q;
    out_result_d   = out_result_q;
    out_flags_d    = out_flags_q;
    out_illegal_d  = out_illegal_q;
    retire_count_d = retire_count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            // ALU operand registers deliberately untouched on illegal ops
            out_result_d  = 32'd0;
            out_flags_d   = 4'b0000;
            out_illegal_d = 1'b1;
            state_d       = RESP;
          end else begin
            alu_a_d       = in_rs1;
            alu_b_d       = dec_use_imm ? in_imm : in_rs2;
            alu_control_d = dec_control;
            state_d       = EXEC;
          end
        end
      end
      EXEC: begin
        out_result_d  = alu_result;
        out_flags_d   = alu_flags;
        out_illegal_d = 1'b0;
        state_d       = RESP;
      end
      RESP: begin
        if (out_ready) begin
          retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_control_q  <= 3'd0;
      out_result_q   <= 32'd0;
      out_flags_q    <= 4'd0;
      out_illegal_q  <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_control_q  <= alu_control_d;
      out_result_q   <= out_result_d;
      out_flags_q    <= out_flags_d;
      out_illegal_q  <= out_illegal_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_control  = alu_control_q;
  assign out_result   = out_result_q;
  assign out_flags    = out_flags_q;
  assign out_illegal  = out_illegal_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU closing the loop
// from alu_a/alu_b/alu_control back to alu_result and flags.
module tb_alu_issue_unit;

  localparam int CNT_W = 16;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [2:0]       in_funct3 = '0;
  logic             in_funct7b5 = 1'b0;
  logic [31:0]      in_rs1 = '0;
  logic [31:0]      in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_control;
  logic [31:0]      alu_result;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic             out_illegal;
  logic [CNT_W-1:0] retire_count;

  alu_issue_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct3    (in_funct3),
    .in_funct7b5  (in_funct7b5),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_illegal  (out_illegal),
    .retire_count (retire_count)
  );

  // behavioural ALU: subtract is a + ~b + 1, so carry means "no borrow"
  logic [31:0] m_b;
  logic [32:0] m_sum;
  always_comb begin
    m_b          = (alu_control == 3'b001) ? ~alu_b : alu_b;
    m_sum        = {1'b0, alu_a} + {1'b0, m_b} + {32'd0, (alu_control == 3'b001)};
    alu_result   = 32'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_control)
      3'b000, 3'b001: begin
        alu_result   = m_sum[31:0];
        alu_carry    = m_sum[32];
        alu_overflow = (alu_a[31] == m_b[31]) && (m_sum[31] != alu_a[31]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
    alu_negative = alu_result[31];
    alu_zero     = (alu_result == 32'd0);
  end

  // scoreboard state
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [CNT_W-1:0] exp_retire = '0;
  logic [2:0]       exp_ctrl   = 3'd0;
  logic [31:0]      exp_a      = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, check it through to the response handshake.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic ill, input logic [2:0] ctrl,
                        input logic [31:0] b_val, input logic [31:0] res,
                        input logic [3:0] flg, input int hold);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (ill) begin
      check({tag, "_valid_1cyc"}, {31'd0, out_valid}, 32'd1);
    end else begin
      exp_ctrl = ctrl;
      exp_a    = rs1;
      check({tag, "_exec_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_alu_b"}, alu_b, b_val);
      @(negedge clk);
      check({tag, "_valid_2cyc"}, {31'd0, out_valid}, 32'd1);
    end
    check({tag, "_alu_ctrl"}, {29'd0, alu_control}, {29'd0, exp_ctrl});
    check({tag, "_alu_a"}, alu_a, exp_a);
    check({tag, "_result"}, out_result, res);
    check({tag, "_flags"}, {28'd0, out_flags}, {28'd0, flg});
    check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_result"}, out_result, res);
      check({tag, "_hold_flags"}, {28'd0, out_flags}, {28'd0, flg});
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_retire"}, {16'd0, retire_count}, {16'd0, exp_retire});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_retire = exp_retire + 1'b1;
    check({tag, "_retire"}, {16'd0, retire_count}, {16'd0, exp_retire});
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // reset values
    #2;
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctrl", {29'd0, alu_control}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_retire", {16'd0, retire_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    //      tag        opcode      f3      f7    rs1           rs2           imm           ill   ctrl    b             result        NZCV     hold
    run_op("add",      7'b0110011, 3'b000, 1'b0, 32'd5,        32'd7,        32'd0,        1'b0, 3'b000, 32'd7,        32'd12,       4'b0000, 0);
    run_op("sub_neg",  7'b0110011, 3'b000, 1'b1, 32'd3,        32'd5,        32'd0,        1'b0, 3'b001, 32'd5,        32'hFFFFFFFE, 4'b1000, 0);
    run_op("sub_zero", 7'b0110011, 3'b000, 1'b1, 32'd5,        32'd5,        32'd0,        1'b0, 3'b001, 32'd5,        32'd0,        4'b0110, 0);
    run_op("addi_f7",  7'b0010011, 3'b000, 1'b1, 32'd10,       32'd99,       32'hFFFFFC00, 1'b0, 3'b000, 32'hFFFFFC00, 32'hFFFFFC0A, 4'b1000, 0);
    run_op("addi_ovf", 7'b0010011, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd0,        32'd1,        1'b0, 3'b000, 32'd1,        32'h80000000, 4'b1001, 0);
    run_op("slt",      7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 3'b101, 32'd1,        32'd1,        4'b0000, 0);
    run_op("ill_f3",   7'b0110011, 3'b001, 1'b0, 32'd123,      32'd456,      32'd0,        1'b1, 3'b000, 32'd0,        32'd0,        4'b0000, 0);
    run_op("or_bp",    7'b0110011, 3'b110, 1'b0, 32'hF0F00000, 32'h00000F0F, 32'd0,        1'b0, 3'b011, 32'h00000F0F, 32'hF0F00F0F, 4'b1000, 5);
    run_op("andi",     7'b0010011, 3'b111, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h0000FF00, 1'b0, 3'b010, 32'h0000FF00, 32'h00005600, 4'b0000, 0);
    run_op("ill_opc",  7'b0110111, 3'b000, 1'b0, 32'd1,        32'd2,        32'd3,        1'b1, 3'b000, 32'd0,        32'd0,        4'b0000, 2);

    // reset asserted mid-EXEC aborts the op and clears everything at once
    @(negedge clk);
    in_opcode = 7'b0110011; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_rs1 = 32'd40; in_rs2 = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_alu_a", alu_a, 32'd40);
    rst = 1'b1;
    #1;
    check("arst_alu_a", alu_a, 32'd0);
    check("arst_alu_b", alu_b, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_retire", {16'd0, retire_count}, 32'd0);
    check("arst_result", out_result, 32'd0);
    check("arst_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_retire = '0;
    exp_ctrl   = 3'd0;
    exp_a      = 32'd0;
    @(negedge clk);
    check("post_rst_no_resp", {31'd0, out_valid}, 32'd0);
    run_op("add_post", 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 3'b000, 32'd1, 32'd2, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front end that drives the combinational ALU: the initiator on the ALU's operand/control interface.
- Accepts one decoded R-type or I-type integer operation per valid/ready handshake, maps it to the 3-bit ALU control code, and registers the ALU operands.
- Captures the ALU result and N/Z/C/V flags one cycle later and returns them on a valid/ready response channel.
- Sits between the decode stage and the register-file writeback path in the multi-cycle datapath variant.

Parameters:
- CNT_W, 16, width of the retired-operation counter (wraps).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- in_opcode  input  7  instruction opcode field.
- in_funct3  input  3  funct3 field.
- in_funct7b5  input  1  instruction bit 30.
- in_rs1  input  32  source operand 1 value.
- in_rs2  input  32  source operand 2 value.
- in_imm  input  32  sign-extended immediate.
- alu_a  output  32  registered ALU operand A.
- alu_b  output  32  registered ALU operand B.
- alu_control  output  3  registered ALU control code.
- alu_result  input  32  ALU result (combinational from alu_a/alu_b/alu_control).
- alu_negative, alu_zero, alu_carry, alu_overflow  input  1 each  ALU flags.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts response.
- out_result  output  32  captured result.
- out_flags  output  4  captured {N,Z,C,V}.
- out_illegal  output  1  request was not a supported operation.
- retire_count  output  CNT_W  count of responses consumed.

Behaviour:
- Reset (async, active-high): state IDLE; alu_a, alu_b, alu_control, out_result, out_flags, out_illegal, and retire_count all 0; out_valid 0.
- in_ready = (state == IDLE). out_valid = (state == RESP).
- IDLE:
  - On in_valid && in_ready: decode the request.
  - If legal: load alu_a, alu_b, alu_control and go to EXEC.
  - If illegal: load out_result = 0, out_flags = 0, out_illegal = 1 and go to RESP. ALU registers are left unchanged.
- EXEC: lasts exactly one cycle. At its end, capture alu_result into out_result, {alu_negative, alu_zero, alu_carry, alu_overflow} into out_flags, set out_illegal = 0, and go to RESP.
- RESP:
  - Hold out_result, out_flags, out_illegal, and out_valid stable until out_valid && out_ready.
  - On that handshake: go to IDLE and increment retire_count (modulo 2^CNT_W).
  - No new request is accepted in the same cycle.
- Latency: accept on edge 0 leads to out_valid high after edge 2 for a legal operation, and after edge 1 for an illegal one.
- Minimum throughput is 1 operation per 3 cycles (2 for illegal).
- Decode: alu_a = in_rs1 always. alu_b = in_rs2 when opcode is 0110011, in_imm when opcode is 0010011. Control codes by funct3:
  - 000: add (code 000); sub (code 001) only when opcode is 0110011 and funct7b5 = 1. For opcode 0010011, funct7b5 is ignored.
  - 010: slt (code 101).
  - 110: or (code 011).
  - 111: and (code 010).
- Illegal: any other opcode, or any other funct3 (001, 011, 100, 101).
- alu_a, alu_b, and alu_control hold their values outside an accept, so the ALU outputs stay stable through EXEC.
- Reset asserted in any state aborts the operation. No response is produced and retire_count clears.

Decomposition:
- Shared package holds:
  - Opcode constants OP_R = 7'b0110011 and OP_I = 7'b0010011.
  - ALU control constants ALU_ADD = 000, ALU_SUB = 001, ALU_AND = 010, ALU_OR = 011, ALU_SLT = 101.
  - Flag index constants N = 3, Z = 2, C = 1, V = 0.
  - FSM state enum {IDLE, EXEC, RESP}.
- One natural sub-module: alu_op_decode, combinational, mapping opcode/funct3/funct7b5 to {alu_control, use_imm, illegal}.

Test Plan:
- R-type add, rs1 = 5, rs2 = 7 -> out_result = 12, out_flags = 0000, out_valid 2 cycles after accept, retire_count = 1 after handshake.
- R-type sub (funct7b5 = 1), rs1 = 3, rs2 = 5 -> out_result = 0xFFFFFFFE, flags N = 1 Z = 0 C = 0 V = 0. Then rs1 = 5, rs2 = 5 -> result 0, Z = 1, C = 1.
- I-type add with funct7b5 = 1, rs1 = 10, imm = 0xFFFFFC00 -> add (not sub), out_result = 0xFFFFFC0A. Also rs1 = 0x7FFFFFFF, imm = 1 -> result 0x80000000, N = 1, V = 1.
- R-type slt, rs1 = 0xFFFFFFFF, rs2 = 1 -> out_result = 1. funct3 = 001 -> out_illegal = 1, result 0, flags 0, out_valid 1 cycle after accept, alu_control unchanged.
- Backpressure: hold out_ready = 0 for 5 cycles in RESP -> outputs stable, in_ready = 0, retire_count unchanged. Raise out_ready -> one increment, IDLE next cycle.
- Assert rst during EXEC -> all outputs 0 immediately (asynchronously), no response. After release, a new add 1 + 1 returns 2.
